// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control unit.
// Sequences fetch, execute, load writeback and interrupt entry.
module otter_cu_fsm #(
   parameter int INTR_SUPPORT = 1
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic       intr,
   input  logic       int_en,
   output logic       pc_clr,
   output logic       pc_write,
   output logic       mem_rden1,
   output logic       mem_rden2,
   output logic       mem_we2,
   output logic       reg_write,
   output logic       csr_we,
   output logic       int_taken,
   output logic       mret_exec,
   output logic [2:0] state_out
);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WB    = 3'd3,
      ST_INTR  = 3'd4
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYS    = 7'b1110011;

   localparam logic [2:0] F3_MRET  = 3'b000;
   localparam logic [2:0] F3_CSRRW = 3'b001;

   state_t state;
   state_t next;

   logic dec_load;
   logic dec_store;
   logic dec_rd;
   logic dec_csrrw;
   logic dec_mret;
   logic intr_cond;

   // Interrupt is only honoured when the feature is built in and enabled.
   assign intr_cond = (INTR_SUPPORT != 0) && intr && int_en;

   // Classify the current instruction for the execute cycle.
   always_comb begin
      dec_load   = 1'b0;
      dec_store  = 1'b0;
      dec_rd     = 1'b0;
      dec_csrrw  = 1'b0;
      dec_mret   = 1'b0;
      case (opcode)
         OP_LOAD:   dec_load  = 1'b1;
         OP_STORE:  dec_store = 1'b1;
         OP_BRANCH: ;
         OP_LUI,
         OP_AUIPC,
         OP_JAL,
         OP_JALR,
         OP_IMM,
         OP_OP:     dec_rd    = 1'b1;
         OP_SYS: begin
            case (func3)
               F3_CSRRW: dec_csrrw = 1'b1;
               F3_MRET:  dec_mret  = 1'b1;
               default:  ;
            endcase
         end
         default:   ;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (clr) state <= ST_INIT;
      else     state <= next;
   end

   // Next-state and strobe generation; clr masks every strobe but pc_clr.
   always_comb begin
      next      = ST_INIT;
      pc_clr    = 1'b0;
      pc_write  = 1'b0;
      mem_rden1 = 1'b0;
      mem_rden2 = 1'b0;
      mem_we2   = 1'b0;
      reg_write = 1'b0;
      csr_we    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
      if (clr) begin
         pc_clr = 1'b1;
         next   = ST_INIT;
      end else begin
         case (state)
            ST_INIT: begin
               pc_clr = 1'b1;
               next   = ST_FETCH;
            end
            ST_FETCH: begin
               mem_rden1 = 1'b1;
               next      = ST_EXEC;
            end
            ST_EXEC: begin
               pc_write  = 1'b1;
               mem_rden2 = dec_load;
               mem_we2   = dec_store;
               reg_write = dec_rd | dec_csrrw;
               csr_we    = dec_csrrw;
               mret_exec = dec_mret;
               if (dec_load)       next = ST_WB;
               else if (intr_cond) next = ST_INTR;
               else                next = ST_FETCH;
            end
            ST_WB: begin
               reg_write = 1'b1;
               next      = intr_cond ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
               pc_write  = 1'b1;
               int_taken = 1'b1;
               next      = ST_FETCH;
            end
            default: begin
               next = ST_INIT;
            end
         endcase
      end
   end

   assign state_out = state;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm.
// Stimulus pushes expected strobes; a negedge monitor pops and compares.
module tb_otter_cu_fsm;

   localparam logic [6:0] LOAD  = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;
   localparam logic [6:0] BR    = 7'b1100011;
   localparam logic [6:0] LUI   = 7'b0110111;
   localparam logic [6:0] JAL   = 7'b1101111;
   localparam logic [6:0] OPI   = 7'b0010011;
   localparam logic [6:0] SYS   = 7'b1110011;
   localparam logic [6:0] UND   = 7'b0000000;

   localparam logic [8:0] PCLR = 9'h100;
   localparam logic [8:0] PWR  = 9'h080;
   localparam logic [8:0] RD1  = 9'h040;
   localparam logic [8:0] RD2  = 9'h020;
   localparam logic [8:0] WE2  = 9'h010;
   localparam logic [8:0] RW   = 9'h008;
   localparam logic [8:0] CSR  = 9'h004;
   localparam logic [8:0] INT  = 9'h002;
   localparam logic [8:0] MRET = 9'h001;

   typedef struct packed {
      logic       c;
      logic [6:0] op;
      logic [2:0] f3;
      logic       ir;
      logic       ie;
      logic [2:0] st;
      logic [8:0] m;
   } vec_t;

   logic       clk = 1'b0;
   logic       clr;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       intr;
   logic       int_en;
   logic       pc_clr, pc_write, mem_rden1, mem_rden2, mem_we2;
   logic       reg_write, csr_we, int_taken, mret_exec;
   logic [2:0] state_out;

   vec_t       vecs[$];
   logic [11:0] sb[$];
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   otter_cu_fsm #(.INTR_SUPPORT(1)) dut (
      .clk(clk), .clr(clr), .opcode(opcode), .func3(func3),
      .intr(intr), .int_en(int_en),
      .pc_clr(pc_clr), .pc_write(pc_write),
      .mem_rden1(mem_rden1), .mem_rden2(mem_rden2),
      .mem_we2(mem_we2), .reg_write(reg_write), .csr_we(csr_we),
      .int_taken(int_taken), .mret_exec(mret_exec),
      .state_out(state_out)
   );

   function automatic vec_t v(input logic c, input logic [6:0] op,
                              input logic [2:0] f3, input logic ir,
                              input logic ie, input logic [2:0] st,
                              input logic [8:0] m);
      vec_t r;
      r.c = c; r.op = op; r.f3 = f3; r.ir = ir; r.ie = ie;
      r.st = st; r.m = m;
      return r;
   endfunction

   // Monitor: compare every cycle an expectation is queued.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         logic [11:0] e;
         logic [11:0] a;
         e = sb.pop_front();
         a = {state_out, pc_clr, pc_write, mem_rden1, mem_rden2,
              mem_we2, reg_write, csr_we, int_taken, mret_exec};
         if (a !== e) begin
            n_err++;
            $display("FAIL cyc%0d: got st=%0d m=%b want st=%0d m=%b",
                     n_vec, a[11:9], a[8:0], e[11:9], e[8:0]);
         end
         n_vec++;
      end
   end

   initial begin
      clr = 1'b1; opcode = OPI; func3 = 3'd0; intr = 1'b0; int_en = 1'b0;
      // reset, then OP-IMM stream
      vecs.push_back(v(1, OPI,   0, 0, 0, 3'd0, PCLR));
      vecs.push_back(v(0, OPI,   0, 0, 0, 3'd0, PCLR));
      vecs.push_back(v(0, OPI,   0, 0, 0, 3'd1, RD1));
      vecs.push_back(v(0, OPI,   0, 0, 0, 3'd2, PWR | RW));
      vecs.push_back(v(0, OPI,   0, 0, 0, 3'd1, RD1));
      vecs.push_back(v(0, OPI,   0, 0, 0, 3'd2, PWR | RW));
      // clr for 2 cycles from FETCH
      vecs.push_back(v(1, OPI,   0, 0, 0, 3'd1, PCLR));
      vecs.push_back(v(1, OPI,   0, 0, 0, 3'd0, PCLR));
      vecs.push_back(v(0, OPI,   0, 0, 0, 3'd0, PCLR));
      vecs.push_back(v(0, OPI,   0, 0, 0, 3'd1, RD1));
      // load
      vecs.push_back(v(0, LOAD,  0, 0, 0, 3'd2, PWR | RD2));
      vecs.push_back(v(0, LOAD,  0, 0, 0, 3'd3, RW));
      vecs.push_back(v(0, STORE, 0, 1, 1, 3'd1, RD1));
      // store with interrupt enabled
      vecs.push_back(v(0, STORE, 0, 1, 1, 3'd2, PWR | WE2));
      vecs.push_back(v(0, STORE, 0, 1, 1, 3'd4, PWR | INT));
      // store with interrupt masked
      vecs.push_back(v(0, STORE, 0, 1, 0, 3'd1, RD1));
      vecs.push_back(v(0, STORE, 0, 1, 0, 3'd2, PWR | WE2));
      vecs.push_back(v(0, STORE, 0, 0, 0, 3'd1, RD1));
      // clr during store execute
      vecs.push_back(v(1, STORE, 0, 0, 0, 3'd2, PCLR));
      vecs.push_back(v(0, SYS,   0, 0, 0, 3'd0, PCLR));
      vecs.push_back(v(0, SYS,   0, 0, 0, 3'd1, RD1));
      // mret, csrrw, undefined, other SYSTEM
      vecs.push_back(v(0, SYS,   0, 0, 0, 3'd2, PWR | MRET));
      vecs.push_back(v(0, SYS,   1, 0, 0, 3'd1, RD1));
      vecs.push_back(v(0, SYS,   1, 0, 0, 3'd2, PWR | RW | CSR));
      vecs.push_back(v(0, UND,   0, 0, 0, 3'd1, RD1));
      vecs.push_back(v(0, UND,   0, 0, 0, 3'd2, PWR));
      vecs.push_back(v(0, SYS,   2, 0, 0, 3'd1, RD1));
      vecs.push_back(v(0, SYS,   2, 0, 0, 3'd2, PWR));
      vecs.push_back(v(0, LOAD,  0, 1, 1, 3'd1, RD1));
      // load with interrupt: goes to WB first, then INTR
      vecs.push_back(v(0, LOAD,  0, 1, 1, 3'd2, PWR | RD2));
      vecs.push_back(v(0, LOAD,  0, 1, 1, 3'd3, RW));
      vecs.push_back(v(0, JAL,   0, 0, 1, 3'd4, PWR | INT));
      // intr pulse in FETCH dropped before sample point
      vecs.push_back(v(0, JAL,   0, 1, 1, 3'd1, RD1));
      vecs.push_back(v(0, JAL,   0, 0, 1, 3'd2, PWR | RW));
      vecs.push_back(v(0, SYS,   0, 1, 1, 3'd1, RD1));
      // mret with pending interrupt still enters INTR
      vecs.push_back(v(0, SYS,   0, 1, 1, 3'd2, PWR | MRET));
      // clr during INTR
      vecs.push_back(v(1, SYS,   0, 1, 1, 3'd4, PCLR));
      vecs.push_back(v(0, BR,    0, 0, 0, 3'd0, PCLR));
      vecs.push_back(v(0, BR,    0, 0, 0, 3'd1, RD1));
      vecs.push_back(v(0, BR,    0, 0, 0, 3'd2, PWR));
      vecs.push_back(v(0, LUI,   0, 0, 0, 3'd1, RD1));
      vecs.push_back(v(0, LUI,   0, 0, 0, 3'd2, PWR | RW));
      vecs.push_back(v(0, LUI,   0, 0, 0, 3'd1, RD1));

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         clr    = vecs[i].c;
         opcode = vecs[i].op;
         func3  = vecs[i].f3;
         intr   = vecs[i].ir;
         int_en = vecs[i].ie;
         sb.push_back({vecs[i].st, vecs[i].m});
      end

      for (int k = 0; k < 5 && sb.size() > 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() > 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Multicycle control-unit state machine that sequences the 32-bit program-counter register and the rest of the MCU datapath.
- Drives PC load and clear, instruction and data memory strobes, and the register-file and CSR write enables.
- Arbitrates between normal instruction flow and interrupt entry.
- Sits between the instruction decoder (opcode and func3 fields) and the PC register, memory and register file.

Parameters:
INTR_SUPPORT, 1, 1 enables the interrupt state; 0 means intr is ignored and ST_INTR is unreachable.

Ports:
clk  input  1  system clock; all state changes on posedge.
clr  input  1  synchronous active-high reset; state returns to ST_INIT on the next posedge.
opcode  input  7  ir[6:0] of the current instruction.
func3  input  3  ir[14:12] of the current instruction.
intr  input  1  level interrupt request.
int_en  input  1  mstatus.MIE; interrupts are taken only when 1.
pc_clr  output  1  drives the PC register clr.
pc_write  output  1  drives the PC register ld.
mem_rden1  output  1  instruction fetch read enable.
mem_rden2  output  1  data read enable.
mem_we2  output  1  data write enable.
reg_write  output  1  register-file write enable.
csr_we  output  1  CSR write enable.
int_taken  output  1  interrupt entry; CSR unit saves mepc and vectors to mtvec.
mret_exec  output  1  mret executing; restores mepc.
state_out  output  3  current state encoding, for debug and verification.

Behaviour:
- State encoding: ST_INIT=0, ST_FETCH=1, ST_EXEC=2, ST_WB=3, ST_INTR=4. Codes 5–7 are illegal and go to ST_INIT on the next edge with all strobes 0.
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: clr=1 at a posedge puts state in ST_INIT regardless of current state.
- Output timing: outputs are combinational from the current state, plus opcode/func3 in ST_EXEC.
- Default strobe value: every strobe is 0 unless listed below.
- While clr=1 (any state): pc_clr=1 and every other strobe is forced to 0 in that same cycle, so no memory or register write can occur during reset. A clr mid-instruction aborts the instruction with no partial side effects beyond earlier cycles.
- ST_INIT: pc_clr=1. Next state ST_FETCH.
- ST_FETCH: mem_rden1=1. Next state ST_EXEC.
- ST_EXEC: pc_write=1 for every opcode. Additional strobes by opcode:
  - LOAD 0000011: mem_rden2=1.
  - STORE 0100011: mem_we2=1.
  - BRANCH 1100011: none.
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP-IMM 0010011, OP 0110011: reg_write=1.
  - SYSTEM 1110011 with func3=001 (csrrw): reg_write=1, csr_we=1.
  - SYSTEM 1110011 with func3=000 (mret): mret_exec=1.
  - Any other SYSTEM func3, or an undefined opcode: no extra strobes (NOP; PC still advances).
- Next state from ST_EXEC:
  - LOAD goes to ST_WB.
  - Otherwise, if INTR_SUPPORT && intr && int_en, go to ST_INTR.
  - Otherwise go to ST_FETCH.
- ST_WB: reg_write=1. Next state ST_INTR if the interrupt condition holds, else ST_FETCH.
- ST_INTR: pc_write=1, int_taken=1. Next state ST_FETCH. A second interrupt cannot be taken until after a full FETCH/EXEC.
- Interrupt sampling: intr is sampled only at the end of ST_EXEC (non-load) or ST_WB. intr asserted in FETCH is held pending by level, not latched; if it drops before the sample point it is not taken.
- Cycle counts: non-load instruction 2 cycles, load 3 cycles, interrupt entry +1 cycle.
- Invariant: pc_write is high exactly once per instruction plus once per taken interrupt.
- Mutual exclusion: mem_we2, mem_rden2 and mem_rden1 are never high in the same cycle.
- mret with intr=1 and int_en=1 still goes to ST_INTR. The CSR unit has already restored mepc on the EXEC edge.

Test Plan:
1. Reset: clr=1 for 2 cycles from an arbitrary state → state_out=0, pc_clr=1, all other strobes 0. Release clr → state_out 0→1→2, mem_rden1=1 in state 1.
2. OP-IMM 0010011 stream, intr=0 → repeating FETCH/EXEC. In EXEC: pc_write=1, reg_write=1, mem_we2=0. Exactly one pc_write per 2 cycles.
3. LOAD 0000011 → FETCH (rden1), EXEC (rden2=1, pc_write=1, reg_write=0), WB (reg_write=1), then FETCH. 3 cycles total.
4. STORE with intr=1:
   - int_en=1 → EXEC mem_we2=1, then ST_INTR (pc_write=1, int_taken=1), then FETCH.
   - Repeat with int_en=0 → no ST_INTR, int_taken never 1.
5. clr=1 asserted during EXEC of STORE → mem_we2=0, pc_write=0 and pc_clr=1 in that cycle. Next state_out=0.
6. Opcode 1110011 with func3=000 → mret_exec=1, pc_write=1. Opcode 1110011 with func3=001 → csr_we=1, reg_write=1. Opcode 0000000 → pc_write=1 only, back to FETCH.
